// File: rtl/sram_mem_controller.sv
// sram_mem_controller
//   MEM-stage data memory sequencer. It turns a 32-bit load or store from the
//   EX/MEM register into two 16-bit half-accesses on an asynchronous SRAM:
//   the lower half first, then the upper half. Each half lasts WAIT_CYCLES
//   cycles. The pipeline freezes on ~ready, which keeps the request stable
//   until the access completes.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   MEM_R_EN, MEM_W_EN        load / store request (store wins if both set)
//   address, ST_val           byte address and store data
//   ready                     1 = idle with no request, or completion cycle
//   read_data                 loaded word, valid in the completion cycle
//   SRAM_ADDR, SRAM_DQ_out    halfword address and write data (registered)
//   SRAM_DQ_in                read data from the SRAM
//   SRAM_DQ_oe                drive SRAM_DQ_out onto the shared bus
//   SRAM_WE_N, SRAM_OE_N      active-low write strobe / output enable
//   SRAM_CE_N/UB_N/LB_N       held low except while in reset
module sram_mem_controller #(
   parameter int unsigned BASE_ADDR   = 1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MEM_R_EN,
   input  logic        MEM_W_EN,
   input  logic [31:0] address,
   input  logic [31:0] ST_val,
   output logic        ready,
   output logic [31:0] read_data,
   output logic [17:0] SRAM_ADDR,
   output logic [15:0] SRAM_DQ_out,
   input  logic [15:0] SRAM_DQ_in,
   output logic        SRAM_DQ_oe,
   output logic        SRAM_WE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N
);

   typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

   localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

   state_t      state, state_n;
   logic [3:0]  cnt, cnt_n;
   logic        op_wr, op_wr_n;
   logic [16:0] idx, idx_n;
   logic [31:0] st_val, st_val_n;
   logic [31:0] offset;
   logic        req, cnt_last, active_n, hi_n;
   logic        unused_offset_bits;

   assign req      = MEM_R_EN | MEM_W_EN;
   assign offset   = address - BASE_ADDR;
   assign cnt_last = (cnt == LAST);
   assign unused_offset_bits = &{1'b0, offset[31:19], offset[1:0]};

   // The request is not acknowledged in the cycle it is first seen, so ready
   // stays low there even though the state is still IDLE.
   assign ready = (state == DONE) || (state == IDLE && !req);

   always_comb begin
      state_n  = state;
      cnt_n    = cnt + 4'd1;
      op_wr_n  = op_wr;
      idx_n    = idx;
      st_val_n = st_val;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (req) begin
               state_n  = LO;
               op_wr_n  = MEM_W_EN;
               idx_n    = offset[18:2];
               st_val_n = ST_val;
            end
         end
         LO: if (cnt_last) begin
            state_n = HI;
            cnt_n   = '0;
         end
         HI: if (cnt_last) begin
            state_n = DONE;
            cnt_n   = '0;
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   assign active_n = (state_n == LO) || (state_n == HI);
   assign hi_n     = (state_n == HI);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         op_wr       <= 1'b0;
         idx         <= '0;
         st_val      <= '0;
         read_data   <= '0;
         SRAM_ADDR   <= '0;
         SRAM_DQ_out <= '0;
         SRAM_WE_N   <= 1'b1;
         SRAM_OE_N   <= 1'b1;
         SRAM_DQ_oe  <= 1'b0;
         SRAM_CE_N   <= 1'b1;
         SRAM_UB_N   <= 1'b1;
         SRAM_LB_N   <= 1'b1;
      end else begin
         state  <= state_n;
         cnt    <= cnt_n;
         op_wr  <= op_wr_n;
         idx    <= idx_n;
         st_val <= st_val_n;
         // SRAM pins are registered from the next-state values. Each pin is
         // then stable for the whole cycle of the state it belongs to.
         SRAM_ADDR   <= {idx_n, hi_n};
         SRAM_DQ_out <= hi_n ? st_val_n[31:16] : st_val_n[15:0];
         SRAM_WE_N   <= !(active_n && op_wr_n);
         SRAM_OE_N   <= !(active_n && !op_wr_n);
         SRAM_DQ_oe  <= active_n && op_wr_n;
         SRAM_CE_N   <= 1'b0;
         SRAM_UB_N   <= 1'b0;
         SRAM_LB_N   <= 1'b0;
         // Sample each half on the last cycle of its phase. This gives the
         // asynchronous SRAM the full WAIT_CYCLES window to settle.
         if (!op_wr && cnt_last) begin
            if (state == LO) read_data[15:0]  <= SRAM_DQ_in;
            if (state == HI) read_data[31:16] <= SRAM_DQ_in;
         end
      end
   end

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Sequences the MEM-stage data memory access for loads/stores leaving the EX/MEM pipeline register.
- Drives an external 16-bit asynchronous SRAM, split into two 16-bit half-accesses per 32-bit word.
- Reports `ready`; the pipeline uses `~ready` as `freeze` for all stage registers, which holds the request stable until completion.
- Sits between the EX/MEM register outputs and the MEM/WB register inputs.

Parameters:
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.
- WAIT_CYCLES, 2, clock cycles per 16-bit half-access; legal range 1..15.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- MEM_R_EN  input  1  load request (held by pipeline while ready=0)
- MEM_W_EN  input  1  store request (held by pipeline while ready=0)
- address  input  32  byte address (ALU_result)
- ST_val  input  32  store data
- ready  output  1  1 = no access pending or access completing this cycle
- read_data  output  32  loaded word
- SRAM_ADDR  output  18  SRAM halfword address
- SRAM_DQ_out  output  16  write data to SRAM
- SRAM_DQ_in  input  16  read data from SRAM
- SRAM_DQ_oe  output  1  1 = drive SRAM_DQ_out onto the bus (top-level tristate)
- SRAM_WE_N  output  1  active-low write strobe
- SRAM_OE_N  output  1  active-low output enable
- SRAM_CE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  tied 0 while not in reset

Behaviour:
- States:
  - IDLE: no access in progress.
  - LO: lower half, SRAM_ADDR = {idx,0}.
  - HI: upper half, SRAM_ADDR = {idx,1}.
  - DONE: completion cycle.
- Address mapping: offset = address - BASE_ADDR (32-bit wrap). idx = offset[18:2], 17 bits. Upper offset bits and offset[1:0] are ignored.
- IDLE:
  - If MEM_R_EN|MEM_W_EN: latch op (write wins when both are 1), latch idx and ST_val, go to LO, counter cleared.
  - Otherwise stay in IDLE.
- LO and HI:
  - Each lasts exactly WAIT_CYCLES cycles, counted by a 4-bit counter.
  - On the last cycle of LO: go to HI with the counter cleared.
  - On the last cycle of HI: go to DONE.
- DONE: lasts 1 cycle, then IDLE unconditionally. A request still asserted in DONE is not restarted; the pipeline advances on this edge.
- `ready`:
  - Combinational.
  - 1 in DONE.
  - 1 in IDLE when MEM_R_EN=MEM_W_EN=0.
  - 0 otherwise, including the IDLE cycle in which a request is first seen.
- Latency: if the request is first seen in cycle 0, ready=1 in cycle 2*WAIT_CYCLES+1 (5 at default) and 0 in cycles 0..2*WAIT_CYCLES.
- Write in LO/HI:
  - SRAM_WE_N=0, SRAM_OE_N=1, SRAM_DQ_oe=1.
  - SRAM_DQ_out = ST_val[15:0] in LO, ST_val[31:16] in HI.
- Read in LO/HI:
  - SRAM_WE_N=1, SRAM_OE_N=0, SRAM_DQ_oe=0.
  - SRAM_DQ_in is sampled on the last cycle of LO into read_data[15:0] and on the last cycle of HI into read_data[31:16].
- Outside LO/HI: SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ_oe=0. SRAM_ADDR and SRAM_DQ_out are don't-care but registered, so no glitches.
- read_data:
  - Valid in DONE.
  - Holds its value until the next read's LO sample.
  - Writes never modify it.
- Latched idx/op/ST_val are used for the whole access; input changes mid-access are ignored.
- Reset values, applied synchronously (rst wins over everything, including mid-access):
  - state=IDLE, counter=0, read_data=0, SRAM_ADDR=0, SRAM_DQ_out=0.
  - SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ_oe=0.
  - SRAM_CE_N=1, SRAM_UB_N=1, SRAM_LB_N=1.
  - ready follows the IDLE rule.
- A write aborted by reset may leave a half-written word; this is acceptable.

Test Plan:
- Reset with no request -> ready=1, SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ_oe=0, read_data=0.
- Write: address=1028, ST_val=0xDEADBEEF, MEM_W_EN=1 held while ready=0, with SRAM model:
  - SRAM_ADDR=2 with DQ_out=0xBEEF and WE_N=0 for 2 cycles.
  - Then SRAM_ADDR=3 with DQ_out=0xDEAD for 2 cycles.
  - ready=1 exactly in cycle 5, then IDLE.
- Read back address=1028, MEM_R_EN=1 -> OE_N=0, DQ_oe=0; read_data=0xDEADBEEF when ready rises in cycle 5.
- Back-to-back: read asserted in the cycle after DONE -> a new access starts with ready=0 immediately; the previous read_data is held until the new LO sample.
- MEM_R_EN=MEM_W_EN=1 at address=1024 -> treated as write: WE_N pulses, read_data unchanged.
- rst asserted in the first HI cycle of a write -> next cycle IDLE, WE_N=1, DQ_oe=0; with the request still held, a fresh access restarts at LO (SRAM_ADDR even).
